// File: rtl/exec_defs.sv
// Shared definitions for the RV32I execute stage: datapath defaults,
// funct3 encodings for ALU and branch ops, and the stage FSM states.
package exec_defs;

    localparam int XLEN_DEFAULT    = 32;
    localparam int SHAMT_W_DEFAULT = 5;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } exec_state_t;

endpackage

// File: rtl/exec_shifter.sv
// Shifter for the execute stage: serial (one bit per cycle) by default,
// single-cycle barrel shifter when EXEC_FAST_SHIFT_EN is defined.
module exec_shifter
    import exec_defs::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int SHAMT_W = SHAMT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic               arith,
    input  logic [XLEN-1:0]    operand,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    value
);

`ifdef EXEC_FAST_SHIFT_EN

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        if (!dir) begin
            value = operand << shamt;
        end else if (arith) begin
            value = $unsigned($signed(operand) >>> shamt);
        end else begin
            value = operand >> shamt;
        end
    end

`else

    logic [SHAMT_W-1:0] count;
    logic [XLEN-1:0]    shreg;
    logic               dir_q;
    logic               arith_q;

    // A zero shift never starts the shifter; the stage completes it directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            shreg   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else if (start && shamt != '0) begin
            count   <= shamt;
            shreg   <= operand;
            dir_q   <= dir;
            arith_q <= arith;
        end else if (count != '0) begin
            count <= count - 1'b1;
            shreg <= value;
        end
    end

    // value is the operand after one more step, so it is final when done is high.
    always_comb begin
        if (dir_q) begin
            value = {arith_q & shreg[XLEN-1], shreg[XLEN-1:1]};
        end else begin
            value = {shreg[XLEN-2:0], 1'b0};
        end
    end

    assign busy = (count != '0);
    assign done = (count == SHAMT_W'(1));

`endif

endmodule

// File: rtl/exec_stage.sv
// RV32I execute stage: ALU, branch/jump resolution and load/store address
// generation with one registered result per instruction (EXEC_FAST_SHIFT_EN selects barrel shifts).
module exec_stage
    import exec_defs::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int SHAMT_W = SHAMT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic            is_store,
    input  logic            is_load,
    input  logic            is_branch,
    input  logic            is_jump,
    input  logic            is_reg,
    input  logic            is_alu,
    input  logic            is_imm,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [XLEN-1:0] branch_dest,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      dest,
    input  logic [2:0]      func3,
    input  logic            func7,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      out_dest,
    output logic            wb_en,
    output logic            out_load,
    output logic            out_store,
    output logic [XLEN-1:0] out_store_data,
    output logic [2:0]      out_func3,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    exec_state_t        state, state_next;
    logic               accept, is_shift_op, goes_serial;
    logic [SHAMT_W-1:0] shamt;
    logic               sh_busy, sh_done;
    logic [XLEN-1:0]    sh_value, alu_res, shift_res;
    logic               taken;
    logic [XLEN-1:0]    result_next, rpc_next;
    logic               wb_next, redir_next;

    logic [XLEN-1:0]    result_q, sdata_q, rpc_q;
    logic [4:0]         dest_q;
    logic [2:0]         f3_q;
    logic               wb_q, load_q, store_q, redir_q;

    assign shamt       = operand_b[SHAMT_W-1:0];
    assign is_shift_op = is_alu && (func3 == F3_SLL || func3 == F3_SR);
    assign in_ready    = !sh_busy;
    assign accept      = in_valid && in_ready;

`ifdef EXEC_FAST_SHIFT_EN
    assign goes_serial = 1'b0;
    assign shift_res   = sh_value;
`else
    assign goes_serial = is_shift_op && (shamt != '0);
    assign shift_res   = operand_a;
`endif

    exec_shifter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_shift_op),
        .shamt   (shamt),
        .dir     (func3[2]),
        .arith   (func7),
        .operand (operand_a),
        .busy    (sh_busy),
        .done    (sh_done),
        .value   (sh_value)
    );

    always_comb begin
        alu_res = '0;
        case (func3)
            F3_ADD:  alu_res = (!is_imm && func7) ? operand_a - operand_b : operand_a + operand_b;
            F3_SLL:  alu_res = shift_res;
            F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            F3_XOR:  alu_res = operand_a ^ operand_b;
            F3_SR:   alu_res = shift_res;
            F3_OR:   alu_res = operand_a | operand_b;
            F3_AND:  alu_res = operand_a & operand_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (func3)
            F3_BEQ:  taken = (operand_a == operand_b);
            F3_BNE:  taken = (operand_a != operand_b);
            F3_BLT:  taken = ($signed(operand_a) <  $signed(operand_b));
            F3_BGE:  taken = ($signed(operand_a) >= $signed(operand_b));
            F3_BLTU: taken = (operand_a <  operand_b);
            F3_BGEU: taken = (operand_a >= operand_b);
            default: taken = 1'b0;
        endcase
    end

    // Unsupported classes (no flag set) still complete, with nothing to write back.
    always_comb begin
        result_next = '0;
        rpc_next    = '0;
        redir_next  = 1'b0;
        wb_next     = 1'b0;
        if (is_jump) begin
            result_next = pc + XLEN'(4);
            redir_next  = 1'b1;
            rpc_next    = is_reg ? ((operand_a + operand_b) & ~XLEN'(1)) : pc + operand_a;
            wb_next     = (dest != 5'd0);
        end else if (is_load || is_store) begin
            result_next = operand_a + operand_b;
            wb_next     = is_load && (dest != 5'd0);
        end else if (is_branch) begin
            redir_next = taken;
            rpc_next   = taken ? pc + branch_dest : '0;
        end else if (is_alu) begin
            result_next = alu_res;
            wb_next     = (dest != 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_next = goes_serial ? ST_SHIFT : ST_DONE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (sh_done) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Serial shifts capture everything at accept and patch in the result on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            rpc_q    <= '0;
            sdata_q  <= '0;
            dest_q   <= '0;
            f3_q     <= '0;
            wb_q     <= 1'b0;
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            redir_q  <= 1'b0;
        end else if (accept) begin
            result_q <= result_next;
            rpc_q    <= rpc_next;
            sdata_q  <= store_data;
            dest_q   <= dest;
            f3_q     <= func3;
            wb_q     <= wb_next;
            load_q   <= is_load && !is_jump;
            store_q  <= is_store && !is_jump && !is_load;
            redir_q  <= redir_next;
        end else if (state == ST_SHIFT && sh_done) begin
            result_q <= sh_value;
        end
    end

    assign out_valid      = (state == ST_DONE);
    assign result         = result_q;
    assign out_dest       = dest_q;
    assign out_store_data = sdata_q;
    assign out_func3      = f3_q;
    assign wb_en          = out_valid && wb_q;
    assign out_load       = out_valid && load_q;
    assign out_store      = out_valid && store_q;
    assign redirect       = out_valid && redir_q;
    assign redirect_pc    = (out_valid && redir_q) ? rpc_q : '0;

endmodule
